// File: rtl/mac_params.sv
// rtl/mac_params.sv - shared MAC datapath constants and TX arbiter state encoding
package mac_params;

  localparam int N_SYMBOLS            = 4;
  localparam int W_SYMBOL             = 8;
  localparam int MAC_TX_ARB_MAX_TRANS = 2304;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_PASS  = 3'b010,
    ST_FLUSH = 3'b100
  } arb_state_e;

endpackage

// File: rtl/mac_rr_arbiter.sv
// rtl/mac_rr_arbiter.sv - combinational round-robin picker, searching from last_grant+1 with wrap
module mac_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         grant_valid,
  output logic [W-1:0] grant_id
);

  logic [W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(last_grant) + i) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arb.sv
// rtl/mac_tx_arb.sv - frame-granular round-robin arbiter sharing the MAC TX stream among N_SRC sources
module mac_tx_arb #(
  parameter int N_SRC     = 4,
  parameter int N_SYMBOLS = mac_params::N_SYMBOLS,
  parameter int W_SYMBOL  = mac_params::W_SYMBOL,
  parameter int MAX_TRANS = mac_params::MAC_TX_ARB_MAX_TRANS
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_clk_en,
  input  logic [N_SRC-1:0]                    i_src_enable,
  input  logic [N_SRC-1:0]                    s_axis_tvalid,
  output logic [N_SRC-1:0]                    s_axis_tready,
  input  logic [N_SRC*N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_SRC*N_SYMBOLS-1:0]          s_axis_tkeep,
  input  logic [N_SRC-1:0]                    s_axis_tlast,
  input  logic [N_SRC-1:0]                    s_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]       m_axis_tdata,
  output logic [N_SYMBOLS-1:0]                m_axis_tkeep,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tuser,
  output logic [$clog2(N_SRC)-1:0]            o_grant_id,
  output logic                                o_busy,
  output logic                                o_timeout
);

  import mac_params::arb_state_e;
  import mac_params::ST_IDLE;
  import mac_params::ST_PASS;
  import mac_params::ST_FLUSH;

  localparam int GW = $clog2(N_SRC);
  localparam int DW = N_SYMBOLS * W_SYMBOL;
  localparam int KW = N_SYMBOLS;
  localparam int CW = $clog2(MAX_TRANS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_TRANS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_TRANS - 1);

  arb_state_e    state, state_n;
  logic [GW-1:0] grant, grant_n;
  logic [GW-1:0] last_grant, last_grant_n;
  logic [CW-1:0] beat_cnt, beat_cnt_n;
  logic          arb_valid;
  logic [GW-1:0] arb_id;
  logic          trunc;

  mac_rr_arbiter #(.N(N_SRC), .W(GW)) u_rr (
    .req         (s_axis_tvalid & i_src_enable),
    .last_grant  (last_grant),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(N_SRC - 1);
      beat_cnt   <= '0;
    end else if (i_clk_en) begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    grant_n       = grant;
    last_grant_n  = last_grant;
    beat_cnt_n    = beat_cnt;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (GW'(i) == grant) begin
        m_axis_tdata = s_axis_tdata[i*DW +: DW];
        m_axis_tkeep = s_axis_tkeep[i*KW +: KW];
      end
    end
    m_axis_tlast  = s_axis_tlast[grant];
    m_axis_tuser  = s_axis_tuser[grant];
    o_timeout     = 1'b0;
    // A source tlast on the final allowed beat is a normal end, not a truncation.
    trunc         = (beat_cnt == LAST_BEAT) && !s_axis_tlast[grant];

    unique case (state)
      ST_IDLE: begin
        if (i_clk_en && arb_valid) begin
          grant_n      = arb_id;
          last_grant_n = arb_id;
          beat_cnt_n   = '0;
          state_n      = ST_PASS;
        end
      end
      ST_PASS: begin
        m_axis_tvalid        = s_axis_tvalid[grant] & i_clk_en;
        s_axis_tready[grant] = m_axis_tready & i_clk_en;
        // Held while the beat waits so the truncated beat stays stable on the bus.
        if (trunc) begin
          m_axis_tlast = 1'b1;
          m_axis_tuser = 1'b0;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (beat_cnt != CNT_MAX) beat_cnt_n = beat_cnt + 1'b1;
          if (s_axis_tlast[grant]) begin
            state_n = ST_IDLE;
          end else if (trunc) begin
            o_timeout = 1'b1;
            state_n   = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        s_axis_tready[grant] = i_clk_en;
        if (i_clk_en && s_axis_tvalid[grant] && s_axis_tlast[grant]) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_grant_id = grant;
  assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mac_tx_arb.sv
// tb/tb_mac_tx_arb.sv - randomized self-checking bench for mac_tx_arb against a frame-level model
module tb_mac_tx_arb;

  localparam int NS = 4;
  localparam int MT = 20;
  localparam int DW = mac_params::N_SYMBOLS * mac_params::W_SYMBOL;
  localparam int KW = mac_params::N_SYMBOLS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clk_en;
  logic [NS-1:0]   src_en, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic            m_tvalid, m_tready, m_tlast, m_tuser;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [1:0]      grant_id;
  logic            busy, timeout;

  always #5 clk = ~clk;

  mac_tx_arb #(.N_SRC(NS), .MAX_TRANS(MT)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_src_enable(src_en),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .o_grant_id(grant_id), .o_busy(busy), .o_timeout(timeout)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  beat_t src_q[NS][$];
  int tests = 0, fails = 0;
  int ce_pct = 100, rdy_pct = 100;
  bit rand_en = 0;
  logic [NS-1:0] en_mask = '1;

  // Frame-level model state and per-test logs.
  int cur = -1, lastg = NS - 1, gid_m = 0, fwd = 0, cycle = 0;
  int ord[$], start_cyc[$], end_cyc[$], out_len[$], lu_q[$];
  int tmo_cnt = 0, out_total = 0, exp_tmo = 0, exp_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_frame(input int s, input int len, input bit rnd_user);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'($urandom);
      b.keep = KW'($urandom);
      b.last = (k == len - 1);
      b.user = rnd_user ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_q[s].push_back(b);
    end
    if (len > MT) exp_tmo++;
    exp_total += (len < MT) ? len : MT;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    ord.delete(); start_cyc.delete(); end_cyc.delete(); out_len.delete(); lu_q.delete();
    tmo_cnt = 0; out_total = 0; exp_tmo = 0; exp_total = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(all_empty() && cur < 0) && n < 20000) begin
      tick();
      n++;
    end
    chk(name, 64'(all_empty() && cur < 0), 64'(1));
  endtask

  // Source and sink stimulus, driven away from the active edge.
  always @(negedge clk) begin
    clk_en   = ($urandom_range(0, 99) < ce_pct);
    m_tready = ($urandom_range(0, 99) < rdy_pct);
    src_en   = rand_en ? NS'($urandom) : en_mask;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i] = 1'b1;
        {s_tdata[i*DW +: DW], s_tkeep[i*KW +: KW], s_tlast[i], s_tuser[i]} = src_q[i][0];
      end else begin
        s_tvalid[i] = 1'b0;
        {s_tdata[i*DW +: DW], s_tkeep[i*KW +: KW], s_tlast[i], s_tuser[i]} = '0;
      end
    end
  end

  // Compare process: checks every cycle against the model, then advances the model.
  always begin
    @(negedge clk);
    #2;
    cycle++;
    if (rst) begin
      cur = -1; lastg = NS - 1; gid_m = 0; fwd = 0;
    end else begin
      logic [NS-1:0] exp_rdy;
      logic exp_v, exp_to;
      beat_t hb, eb;
      exp_rdy = '0; exp_v = 1'b0; exp_to = 1'b0; hb = '0;
      chk("busy", 64'(busy), 64'(cur >= 0));
      chk("grant_id", 64'(grant_id), 64'(gid_m));
      if (cur >= 0 && clk_en) begin
        if (fwd == MT) exp_rdy[cur] = 1'b1;
        else begin
          exp_rdy[cur] = m_tready;
          exp_v = (src_q[cur].size() > 0);
        end
      end
      chk("s_tready", 64'(s_tready), 64'(exp_rdy));
      chk("m_tvalid", 64'(m_tvalid), 64'(exp_v));
      if (exp_v) begin
        hb = src_q[cur][0];
        eb = hb;
        if (fwd == MT - 1 && !hb.last) begin
          eb.last = 1'b1;
          eb.user = 1'b0;
        end
        chk("m_beat", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'(eb));
        exp_to = m_tready && fwd == MT - 1 && !hb.last;
        if (m_tready) begin
          out_total++;
          if (eb.last) lu_q.push_back(int'(eb.user));
        end
      end
      chk("timeout", 64'(timeout), 64'(exp_to));
      if (cur >= 0) begin
        if (clk_en && exp_rdy[cur] && src_q[cur].size() > 0) begin
          hb = src_q[cur].pop_front();
          if (fwd < MT) begin
            fwd++;
            if (fwd == 1) start_cyc.push_back(cycle);
          end
          if (exp_to) tmo_cnt++;
          if (hb.last) begin
            end_cyc.push_back(cycle);
            out_len.push_back(fwd);
            cur = -1;
          end
        end
      end else if (clk_en) begin
        for (int k = 1; k <= NS; k++)
          if (cur < 0 && src_en[(lastg + k) % NS] && src_q[(lastg + k) % NS].size() > 0)
            cur = (lastg + k) % NS;
        if (cur >= 0) begin
          lastg = cur; gid_m = cur; fwd = 0;
          ord.push_back(cur);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #3;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_mvalid", 64'(m_tvalid), 64'(0));
    chk("rst_sready", 64'(s_tready), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    tick();

    // Single 16-beat frame from source 0.
    clear_log();
    add_frame(0, 16, 0);
    wait_idle("t1_done");
    chk("t1_order", 64'(ord.size() == 1 && ord[0] == 0), 64'(1));
    chk("t1_len", 64'(out_len[0]), 64'(16));
    chk("t1_user", 64'(lu_q[0]), 64'(1));

    // All four sources: order 0,1,2,3,0 with exactly one idle cycle between frames.
    do_reset();
    add_frame(0, 4, 1); add_frame(0, 4, 1);
    for (int i = 1; i < NS; i++) add_frame(i, 4, 1);
    wait_idle("t2_done");
    chk("t2_nframes", 64'(ord.size()), 64'(5));
    if (ord.size() == 5) begin
      chk("t2_o0", 64'(ord[0]), 64'(0)); chk("t2_o1", 64'(ord[1]), 64'(1));
      chk("t2_o2", 64'(ord[2]), 64'(2)); chk("t2_o3", 64'(ord[3]), 64'(3));
      chk("t2_o4", 64'(ord[4]), 64'(0));
      for (int k = 0; k < 4; k++) chk("t2_gap", 64'(start_cyc[k+1] - end_cyc[k]), 64'(2));
    end

    // Source 2 masked: order 0,1,3,0 and source 2 left waiting.
    do_reset();
    en_mask = 4'b1011;
    add_frame(0, 3, 1); add_frame(0, 3, 1);
    for (int i = 1; i < NS; i++) add_frame(i, 3, 1);
    for (int n = 0; n < 500 && !(ord.size() >= 4 && cur < 0); n++) tick();
    chk("t3_nframes", 64'(ord.size()), 64'(4));
    if (ord.size() == 4) begin
      chk("t3_o0", 64'(ord[0]), 64'(0)); chk("t3_o1", 64'(ord[1]), 64'(1));
      chk("t3_o2", 64'(ord[2]), 64'(3)); chk("t3_o3", 64'(ord[3]), 64'(0));
    end
    chk("t3_src2_pending", 64'(src_q[2].size()), 64'(3));
    src_q[2].delete();
    en_mask = '1;
    tick();

    // Watchdog: a MT+4 beat frame is cut at MT, the rest flushed, then source 2 follows.
    do_reset();
    add_frame(1, MT + 4, 0);
    for (int n = 0; n < 50 && cur != 1; n++) tick();
    add_frame(2, 3, 0);
    wait_idle("t4_done");
    chk("t4_order", 64'(ord.size() == 2 && ord[0] == 1 && ord[1] == 2), 64'(1));
    chk("t4_tmo", 64'(tmo_cnt), 64'(1));
    chk("t4_len", 64'(out_len[0]), 64'(MT));
    chk("t4_user", 64'(lu_q[0]), 64'(0));
    chk("t4_gap", 64'(start_cyc[1] - end_cyc[0]), 64'(2));
    add_frame(3, MT, 0);
    wait_idle("t4b_done");
    chk("t4b_tmo", 64'(tmo_cnt), 64'(1));
    chk("t4b_len", 64'(out_len[2]), 64'(MT));
    chk("t4b_user", 64'(lu_q[2]), 64'(1));

    // Reset on beat 5 of a frame, then source 0 must win first.
    do_reset();
    add_frame(0, 10, 0);
    for (int n = 0; n < 100 && !(cur == 0 && fwd == 4); n++) tick();
    chk("t5_reached", 64'(fwd), 64'(4));
    do_reset();
    @(negedge clk); #3;
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_grant", 64'(grant_id), 64'(0));
    chk("t5_mvalid", 64'(m_tvalid), 64'(0));
    chk("t5_sready", 64'(s_tready), 64'(0));
    tick();
    add_frame(1, 3, 0); add_frame(0, 3, 0);
    wait_idle("t5_done");
    chk("t5_first", 64'(ord[0]), 64'(0));

    // Random clk_en, tready, enables and frame lengths.
    do_reset();
    ce_pct = 50; rdy_pct = 50; rand_en = 1;
    add_frame(2, 10, 1);
    for (int f = 0; f < 30; f++) add_frame($urandom_range(0, NS - 1), $urandom_range(1, MT + 5), 1);
    for (int n = 0; n < 20000 && !all_empty(); n++) tick();
    rand_en = 0;
    wait_idle("t6_done");
    chk("t6_total", 64'(out_total), 64'(exp_total));
    chk("t6_tmo", 64'(tmo_cnt), 64'(exp_tmo));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
